boot_loader: RTL and testbench

Byte-stream program loader that sits directly upstream of the cpu core. It holds the core in reset and receives a framed program image from a byte source, such as a UART receiver. It writes the image into program memory as 16-bit words, then verifies a checksum. On a good checksum it releases the core to execute from LOAD_BASE.

---
 rtl/ucisc_boot_pkg.sv | 33 +++
 rtl/boot_loader.sv | 131 +++++++++++++
 tb/tb_boot_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ucisc_boot_pkg.sv
// Shared definitions for the byte-stream program loader: state encoding, frame layout, sync marker.
package ucisc_boot_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_SUM_HI,
    S_SUM_LO,
    S_RUN,
    S_ERROR
  } boot_state_e;

  // Order of fields on the wire; all multi-byte fields are big-endian.
  typedef enum logic [2:0] {
    FLD_SYNC,
    FLD_LEN_HI,
    FLD_LEN_LO,
    FLD_DATA_HI,
    FLD_DATA_LO,
    FLD_SUM_HI,
    FLD_SUM_LO
  } frame_field_e;

  function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Holds the core in reset, loads a framed big-endian image into program memory, checks the sum,
// then releases the core. Accepts a byte every cycle; rx_ready is always high.
module boot_loader
  import ucisc_boot_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = '0,
  parameter int                    MAX_WORDS  = 4096,
  parameter logic [7:0]            SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                  clock_input,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_write,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  boot_state_e r_state;
  boot_state_e w_state_nxt;

  logic [7:0]            r_hi;
  logic [15:0]           r_len;
  logic [15:0]           r_idx;
  logic [15:0]           r_sum;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]           r_mem_data;
  logic                  r_mem_write;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;

  logic                  w_acc;
  logic                  w_is_sync;
  logic [15:0]           w_word;
  logic [15:0]           w_idx_inc;
  logic                  w_sum_ok;
  logic                  w_clear;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign rx_ready  = 1'b1;
  assign w_acc     = rx_valid;
  assign w_is_sync = (rx_data == SYNC_BYTE);
  assign w_word    = be_word(r_hi, rx_data);
  assign w_idx_inc = r_idx + 16'd1;
  assign w_sum_ok  = (w_word == r_sum);
  assign w_wr      = w_acc && (r_state == S_DATA_LO);
  assign w_addr    = ADDR_WIDTH'(32'(LOAD_BASE) + 32'(r_idx));
  // Every path into LEN_HI starts a fresh frame.
  assign w_clear   = (w_state_nxt == S_LEN_HI) && (r_state != S_LEN_HI);

  always_ff @(posedge clock_input) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        S_IDLE:    if (w_is_sync) w_state_nxt = S_LEN_HI;
        S_LEN_HI:  w_state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if (32'(w_word) > 32'(MAX_WORDS)) w_state_nxt = S_ERROR;
          else if (w_word == 16'd0)         w_state_nxt = S_SUM_HI;
          else                              w_state_nxt = S_DATA_HI;
        end
        S_DATA_HI: w_state_nxt = S_DATA_LO;
        S_DATA_LO: w_state_nxt = (w_idx_inc == r_len) ? S_SUM_HI : S_DATA_HI;
        S_SUM_HI:  w_state_nxt = S_SUM_LO;
        S_SUM_LO:  w_state_nxt = w_sum_ok ? S_RUN : S_ERROR;
        S_RUN:     if (w_is_sync) w_state_nxt = S_LEN_HI;
        S_ERROR:   if (w_is_sync) w_state_nxt = S_LEN_HI;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_input) begin
    if (reset) begin
      r_hi        <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_write <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_write <= w_wr;
      r_done      <= w_acc && (r_state == S_SUM_LO) && w_sum_ok;
      // Core runs only in RUN; the flags follow the next state so they change on the deciding edge.
      r_cpu_reset <= (w_state_nxt != S_RUN);
      r_error     <= (w_state_nxt == S_ERROR);
      if (w_acc && (r_state == S_LEN_HI || r_state == S_DATA_HI || r_state == S_SUM_HI)) begin
        r_hi <= rx_data;
      end
      if (w_acc && r_state == S_LEN_LO) begin
        r_len <= w_word;
      end
      if (w_clear) begin
        r_idx <= '0;
        r_sum <= '0;
      end else if (w_wr) begin
        r_idx      <= w_idx_inc;
        r_sum      <= r_sum + w_word;
        r_mem_addr <= w_addr;
        r_mem_data <= w_word;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_write = r_mem_write;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances (base 0000 and base FFFF) see the same byte stream.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        rx_ready,  rx_ready2;
  logic [15:0] mem_addr,  mem_addr2;
  logic [15:0] mem_data,  mem_data2;
  logic        mem_write, mem_write2;
  logic        cpu_reset, cpu_reset2;
  logic        done,      done2;
  logic        error,     error2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wq[$];
  logic [31:0] wq2[$];
  int          done_cnt;
  logic [7:0]  fr[$];

  always #5 clk = ~clk;

  boot_loader u_dut (
    .clock_input(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  boot_loader #(.LOAD_BASE(16'hFFFF)) u_wrap (
    .clock_input(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready2), .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_write(mem_write2),
    .cpu_reset(cpu_reset2), .done(done2), .error(error2)
  );

  // Log writes and done pulses well after each rising edge, away from input changes.
  always @(posedge clk) begin
    #2;
    if (mem_write)  wq.push_back({mem_addr, mem_data});
    if (mem_write2) wq2.push_back({mem_addr2, mem_data2});
    if (done)       done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wq.delete();
    wq2.delete();
    done_cnt = 0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_fr(input int maxgap);
    foreach (fr[i]) begin
      send(fr[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({pfx, "_rx_ready"},  32'(rx_ready),  32'd1);
    chk({pfx, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({pfx, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({pfx, "_mem_data"},  32'(mem_data),  32'd0);
    chk({pfx, "_done"},      32'(done),      32'd0);
    chk({pfx, "_error"},     32'(error),     32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    done_cnt = 0;
    @(negedge clk);
    do_reset();
    chk_reset_vals("rst");
    reset = 1'b0;
    idle(2);

    // Basic load, also checks address wrap on the FFFF-based instance.
    clr();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    send_fr(0);
    chk("basic_done_edge", 32'(done), 32'd1);
    chk("basic_cpu_rel", 32'(cpu_reset), 32'd0);
    idle(1);
    chk("basic_done_pulse", 32'(done), 32'd0);
    idle(2);
    chk("basic_nwr", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("basic_wr0", wq[0], 32'h0000_1234);
      chk("basic_wr1", wq[1], 32'h0001_ABCD);
    end
    chk("basic_ndone", done_cnt, 32'd1);
    chk("basic_err", 32'(error), 32'd0);
    chk("wrap_nwr", wq2.size(), 32'd2);
    if (wq2.size() == 2) begin
      chk("wrap_wr0", wq2[0], 32'hFFFF_1234);
      chk("wrap_wr1", wq2[1], 32'h0000_ABCD);
    end
    chk("wrap_done", 32'(cpu_reset2), 32'd0);

    // Bad checksum, then recovery with a good frame.
    clr();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
    send_fr(0);
    idle(2);
    chk("bad_err", 32'(error), 32'd1);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bad_ndone", done_cnt, 32'd0);
    clr();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    send_fr(0);
    idle(2);
    chk("recov_err", 32'(error), 32'd0);
    chk("recov_ndone", done_cnt, 32'd1);
    chk("recov_cpu_reset", 32'(cpu_reset), 32'd0);

    // Zero-length image.
    clr();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_fr(0);
    idle(2);
    chk("zero_nwr", wq.size(), 32'd0);
    chk("zero_ndone", done_cnt, 32'd1);
    chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);

    // Length MAX_WORDS+1 is rejected right after LEN_LO.
    clr();
    fr = '{8'hA5, 8'h10, 8'h01};
    send_fr(0);
    chk("long_err_edge", 32'(error), 32'd1);
    idle(2);
    chk("long_nwr", wq.size(), 32'd0);
    chk("long_cpu_reset", 32'(cpu_reset), 32'd1);

    // Exactly MAX_WORDS words: word i = i, sum = 0x7FF800 mod 2^16 = F800.
    clr();
    send(8'hA5);
    chk("max_err_clr", 32'(error), 32'd0);
    send(8'h10);
    send(8'h00);
    for (int i = 0; i < 4096; i++) begin
      logic [15:0] w;
      w = 16'(i);
      send(w[15:8]);
      send(w[7:0]);
    end
    send(8'hF8);
    send(8'h00);
    idle(2);
    chk("max_nwr", wq.size(), 32'd4096);
    if (wq.size() == 4096) chk("max_last", wq[4095], 32'h0FFF_0FFF);
    chk("max_ndone", done_cnt, 32'd1);

    // Re-arm from RUN: console byte ignored, sync raises cpu_reset.
    send(8'h41);
    idle(2);
    chk("rearm_noise", 32'(cpu_reset), 32'd0);
    send(8'hA5);
    chk("rearm_cpu_reset", 32'(cpu_reset), 32'd1);

    // Reset in the middle of the data phase.
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_fr(0);
    do_reset();
    chk_reset_vals("midrst");
    reset = 1'b0;
    idle(1);
    clr();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    send_fr(0);
    idle(2);
    if (wq.size() > 0) chk("midrst_first_addr", wq[0], 32'h0000_1234);
    else chk("midrst_nwr", wq.size(), 32'd2);
    chk("midrst_ndone", done_cnt, 32'd1);

    // Leading noise and random valid gaps from IDLE.
    do_reset();
    reset = 1'b0;
    idle(1);
    clr();
    fr = '{8'hFF, 8'h00, 8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_fr(3);
    idle(2);
    chk("noise_nwr", wq.size(), 32'd1);
    if (wq.size() == 1) chk("noise_wr0", wq[0], 32'h0000_FFFF);
    chk("noise_ndone", done_cnt, 32'd1);
    chk("noise_err", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
